// File: rtl/vx_amo_engine_if.sv
// Bus interfaces for the AMO engine: core-side port (with AMO fields) and cache-bank port.

interface vx_amo_core_if #(
  parameter int unsigned TAG_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = 26,
  parameter int unsigned WORD_SIZE  = 4,
  parameter int unsigned GTID_WIDTH = 10
);
  localparam int unsigned W = 8 * WORD_SIZE;

  logic                  req_valid;
  logic                  req_ready;
  logic [TAG_WIDTH-1:0]  req_tag;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_rw;
  logic [WORD_SIZE-1:0]  req_byteen;
  logic [W-1:0]          req_data;
  logic                  req_amo;
  logic [4:0]            req_amo_op;
  logic [GTID_WIDTH-1:0] req_gtid;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [TAG_WIDTH-1:0]  rsp_tag;
  logic [W-1:0]          rsp_data;

  modport master (
    output req_valid, req_tag, req_addr, req_rw, req_byteen, req_data,
           req_amo, req_amo_op, req_gtid, rsp_ready,
    input  req_ready, rsp_valid, rsp_tag, rsp_data
  );

  modport slave (
    input  req_valid, req_tag, req_addr, req_rw, req_byteen, req_data,
           req_amo, req_amo_op, req_gtid, rsp_ready,
    output req_ready, rsp_valid, rsp_tag, rsp_data
  );
endinterface

interface vx_amo_cache_if #(
  parameter int unsigned TAG_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = 26,
  parameter int unsigned WORD_SIZE  = 4
);
  localparam int unsigned W = 8 * WORD_SIZE;

  logic                  req_valid;
  logic                  req_ready;
  logic [TAG_WIDTH-1:0]  req_tag;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_rw;
  logic [WORD_SIZE-1:0]  req_byteen;
  logic [W-1:0]          req_data;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [TAG_WIDTH-1:0]  rsp_tag;
  logic [W-1:0]          rsp_data;

  modport master (
    output req_valid, req_tag, req_addr, req_rw, req_byteen, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_tag, rsp_data
  );

  modport slave (
    input  req_valid, req_tag, req_addr, req_rw, req_byteen, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_tag, rsp_data
  );
endinterface

// File: rtl/vx_amo_engine.sv
// RISC-V 'A' engine between core port and one cache bank: read/compute/write AMOs,
// per-thread LR reservation table, pass-through of all other traffic.

module vx_amo_engine #(
  parameter int unsigned TAG_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH    = 26,
  parameter int unsigned WORD_SIZE     = 4,
  parameter int unsigned GTID_WIDTH    = 10,
  parameter int unsigned NUM_RSV       = 4,
  parameter int unsigned RSV_GRAN_BITS = 2,
  parameter int unsigned RSV_TIMEOUT   = 1024,
  parameter int unsigned MAX_PENDING   = 8,
  parameter int unsigned WRITE_ACK     = 0
) (
  input  logic           clk,
  input  logic           reset,
  vx_amo_core_if.slave   core_if,
  vx_amo_cache_if.master cache_if
);
  localparam int unsigned W      = 8 * WORD_SIZE;
  localparam int unsigned GRAN_W = ADDR_WIDTH - RSV_GRAN_BITS;
  localparam int unsigned AGE_W  = (RSV_TIMEOUT > 1) ? $clog2(RSV_TIMEOUT) : 1;
  localparam int unsigned RR_W   = (NUM_RSV > 1) ? $clog2(NUM_RSV) : 1;
  localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_LR   = 5'b00010;
  localparam logic [4:0] OP_SC   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_OR   = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01100;
  localparam logic [4:0] OP_MIN  = 5'b10000;
  localparam logic [4:0] OP_MAX  = 5'b10100;
  localparam logic [4:0] OP_MINU = 5'b11000;
  localparam logic [4:0] OP_MAXU = 5'b11100;

  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_RSP
  } state_e;

  state_e state_q, state_d;
  logic [PEND_W-1:0]     pending_q, pending_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0]  byteen_q, byteen_d;
  logic [W-1:0]          data_q, data_d;
  logic [4:0]            op_q, op_d;
  logic [GTID_WIDTH-1:0] gtid_q, gtid_d;
  logic [W-1:0]          old_q, old_d;
  logic                  sc_fail_q, sc_fail_d;

  logic                  rsv_valid_q [NUM_RSV];
  logic                  rsv_valid_d [NUM_RSV];
  logic [GTID_WIDTH-1:0] rsv_gtid_q  [NUM_RSV];
  logic [GTID_WIDTH-1:0] rsv_gtid_d  [NUM_RSV];
  logic [GRAN_W-1:0]     rsv_gran_q  [NUM_RSV];
  logic [GRAN_W-1:0]     rsv_gran_d  [NUM_RSV];
  logic [AGE_W-1:0]      rsv_age_q   [NUM_RSV];
  logic [AGE_W-1:0]      rsv_age_d   [NUM_RSV];
  logic                  rsv_expire  [NUM_RSV];
  logic [RR_W-1:0]       rr_q, rr_d;

  logic                  core_req_ready_c, core_rsp_valid_c;
  logic [TAG_WIDTH-1:0]  core_rsp_tag_c;
  logic [W-1:0]          core_rsp_data_c;
  logic                  cache_req_valid_c, cache_req_rw_c, cache_rsp_ready_c;
  logic [TAG_WIDTH-1:0]  cache_req_tag_c;
  logic [ADDR_WIDTH-1:0] cache_req_addr_c;
  logic [WORD_SIZE-1:0]  cache_req_byteen_c;
  logic [W-1:0]          cache_req_data_c;

  logic            pend_full, pass_ok;
  logic            amo_accept, rd_rsp_fire, cache_req_fire, pass_rd_fire, cache_rsp_fire;
  logic            sc_ok, lr_hit, lr_free;
  logic [RR_W-1:0] lr_slot;
  logic [W-1:0]    amo_result;
  logic [GRAN_W-1:0] req_gran, wr_gran;

  assign pend_full      = pending_q >= PEND_W'(MAX_PENDING);
  assign amo_accept     = (state_q == S_IDLE) && core_if.req_valid && core_if.req_amo;
  assign rd_rsp_fire    = (state_q == S_RD_WAIT) && cache_if.rsp_valid;
  assign cache_req_fire = cache_req_valid_c && cache_if.req_ready;
  assign pass_rd_fire   = (state_q == S_IDLE) && !core_if.req_amo && !core_if.req_rw &&
                          core_if.req_valid && core_req_ready_c;
  assign cache_rsp_fire = ((state_q == S_IDLE) || (state_q == S_DRAIN)) &&
                          cache_if.rsp_valid && cache_rsp_ready_c;
  assign req_gran       = addr_q[ADDR_WIDTH-1:RSV_GRAN_BITS];
  assign wr_gran        = cache_req_addr_c[ADDR_WIDTH-1:RSV_GRAN_BITS];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (amo_accept) state_d = (pending_q != '0) ? S_DRAIN : S_RD_REQ;
      S_DRAIN:   if (pending_q == '0) state_d = S_RD_REQ;
      S_RD_REQ:  if (cache_req_fire) state_d = S_RD_WAIT;
      S_RD_WAIT: if (cache_if.rsp_valid) begin
                   if (op_q == OP_LR)      state_d = S_RSP;
                   else if (op_q == OP_SC) state_d = sc_ok ? S_WR_REQ : S_RSP;
                   else                    state_d = S_WR_REQ;
                 end
      S_WR_REQ:  if (cache_req_fire) state_d = (WRITE_ACK != 0) ? S_WR_WAIT : S_RSP;
      S_WR_WAIT: if (cache_if.rsp_valid) state_d = S_RSP;
      S_RSP:     if (core_if.rsp_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Port outputs per state; reads are held off at the core when the pending counter is full
  always_comb begin
    pass_ok            = core_if.req_rw || !pend_full;
    core_req_ready_c   = 1'b0;
    core_rsp_valid_c   = 1'b0;
    core_rsp_tag_c     = tag_q;
    core_rsp_data_c    = old_q;
    cache_req_valid_c  = 1'b0;
    cache_req_tag_c    = tag_q;
    cache_req_addr_c   = addr_q;
    cache_req_rw_c     = 1'b0;
    cache_req_byteen_c = byteen_q;
    cache_req_data_c   = data_q;
    cache_rsp_ready_c  = 1'b0;
    case (state_q)
      S_IDLE, S_DRAIN: begin
        core_rsp_valid_c  = cache_if.rsp_valid;
        core_rsp_tag_c    = cache_if.rsp_tag;
        core_rsp_data_c   = cache_if.rsp_data;
        cache_rsp_ready_c = core_if.rsp_ready;
        if (state_q == S_IDLE) begin
          if (core_if.req_amo) begin
            core_req_ready_c = 1'b1;
          end else begin
            cache_req_valid_c  = core_if.req_valid && pass_ok;
            cache_req_tag_c    = core_if.req_tag;
            cache_req_addr_c   = core_if.req_addr;
            cache_req_rw_c     = core_if.req_rw;
            cache_req_byteen_c = core_if.req_byteen;
            cache_req_data_c   = core_if.req_data;
            core_req_ready_c   = cache_if.req_ready && pass_ok;
          end
        end
      end
      S_RD_REQ:  cache_req_valid_c = 1'b1;
      S_RD_WAIT: cache_rsp_ready_c = 1'b1;
      S_WR_REQ: begin
        cache_req_valid_c = 1'b1;
        cache_req_rw_c    = 1'b1;
        cache_req_data_c  = amo_result;
      end
      S_WR_WAIT: cache_rsp_ready_c = 1'b1;
      S_RSP: begin
        core_rsp_valid_c = 1'b1;
        if (op_q == OP_SC) core_rsp_data_c = W'(sc_fail_q);
      end
      default: ;
    endcase
  end

  assign core_if.req_ready    = core_req_ready_c;
  assign core_if.rsp_valid    = core_rsp_valid_c;
  assign core_if.rsp_tag      = core_rsp_tag_c;
  assign core_if.rsp_data     = core_rsp_data_c;
  assign cache_if.req_valid   = cache_req_valid_c;
  assign cache_if.req_tag     = cache_req_tag_c;
  assign cache_if.req_addr    = cache_req_addr_c;
  assign cache_if.req_rw      = cache_req_rw_c;
  assign cache_if.req_byteen  = cache_req_byteen_c;
  assign cache_if.req_data    = cache_req_data_c;
  assign cache_if.rsp_ready   = cache_rsp_ready_c;

  // AMO arithmetic on the old word and the latched operand; unknown codes act as SWAP
  always_comb begin
    amo_result = data_q;
    case (op_q)
      OP_ADD:  amo_result = old_q + data_q;
      OP_XOR:  amo_result = old_q ^ data_q;
      OP_OR:   amo_result = old_q | data_q;
      OP_AND:  amo_result = old_q & data_q;
      OP_MIN:  amo_result = ($signed(old_q) < $signed(data_q)) ? old_q : data_q;
      OP_MAX:  amo_result = ($signed(old_q) > $signed(data_q)) ? old_q : data_q;
      OP_MINU: amo_result = (old_q < data_q) ? old_q : data_q;
      OP_MAXU: amo_result = (old_q > data_q) ? old_q : data_q;
      default: amo_result = data_q;
    endcase
  end

  // Request latch, old-data capture and pass-through read counter
  always_comb begin
    tag_d     = tag_q;
    addr_d    = addr_q;
    byteen_d  = byteen_q;
    data_d    = data_q;
    op_d      = op_q;
    gtid_d    = gtid_q;
    old_d     = old_q;
    sc_fail_d = sc_fail_q;
    pending_d = pending_q;
    if (amo_accept) begin
      tag_d    = core_if.req_tag;
      addr_d   = core_if.req_addr;
      byteen_d = core_if.req_byteen;
      data_d   = core_if.req_data;
      op_d     = core_if.req_amo_op;
      gtid_d   = core_if.req_gtid;
    end
    if (rd_rsp_fire) begin
      old_d     = cache_if.rsp_data;
      sc_fail_d = !sc_ok;
    end
    if (pass_rd_fire && !cache_rsp_fire)      pending_d = pending_q + PEND_W'(1);
    else if (!pass_rd_fire && cache_rsp_fire) pending_d = pending_q - PEND_W'(1);
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q     <= '0;
      addr_q    <= '0;
      byteen_q  <= '0;
      data_q    <= '0;
      op_q      <= '0;
      gtid_q    <= '0;
      old_q     <= '0;
      sc_fail_q <= 1'b0;
      pending_q <= '0;
    end else begin
      tag_q     <= tag_d;
      addr_q    <= addr_d;
      byteen_q  <= byteen_d;
      data_q    <= data_d;
      op_q      <= op_d;
      gtid_q    <= gtid_d;
      old_q     <= old_d;
      sc_fail_q <= sc_fail_d;
      pending_q <= pending_d;
    end
  end

  // Expiry flags, SC match and LR slot choice (same-gtid entry, else lowest free, else RR victim)
  always_comb begin
    sc_ok   = 1'b0;
    lr_hit  = 1'b0;
    lr_free = 1'b0;
    lr_slot = rr_q;
    for (int i = 0; i < int'(NUM_RSV); i++) begin
      rsv_expire[i] = (RSV_TIMEOUT != 0) && rsv_valid_q[i] &&
                      (rsv_age_q[i] == AGE_W'(RSV_TIMEOUT - 1));
      if (rsv_valid_q[i] && !rsv_expire[i] && rsv_gtid_q[i] == gtid_q && rsv_gran_q[i] == req_gran)
        sc_ok = 1'b1;
      if (!lr_hit && rsv_valid_q[i] && rsv_gtid_q[i] == gtid_q) begin
        lr_hit  = 1'b1;
        lr_slot = RR_W'(i);
      end
    end
    if (!lr_hit) begin
      for (int i = 0; i < int'(NUM_RSV); i++) begin
        if (!lr_free && !rsv_valid_q[i]) begin
          lr_free = 1'b1;
          lr_slot = RR_W'(i);
        end
      end
    end
  end

  // Table update: ageing/expiry, write-granule invalidation, SC clear, LR install (LR wins)
  always_comb begin
    rr_d = rr_q;
    for (int i = 0; i < int'(NUM_RSV); i++) begin
      rsv_valid_d[i] = rsv_valid_q[i] && !rsv_expire[i];
      rsv_gtid_d[i]  = rsv_gtid_q[i];
      rsv_gran_d[i]  = rsv_gran_q[i];
      rsv_age_d[i]   = (RSV_TIMEOUT != 0 && rsv_valid_q[i]) ? rsv_age_q[i] + AGE_W'(1) : rsv_age_q[i];
      if (cache_req_fire && cache_req_rw_c && rsv_gran_q[i] == wr_gran)
        rsv_valid_d[i] = 1'b0;
      if (rd_rsp_fire && op_q == OP_SC && rsv_gtid_q[i] == gtid_q)
        rsv_valid_d[i] = 1'b0;
    end
    if (rd_rsp_fire && op_q == OP_LR) begin
      rsv_valid_d[lr_slot] = 1'b1;
      rsv_gtid_d[lr_slot]  = gtid_q;
      rsv_gran_d[lr_slot]  = req_gran;
      rsv_age_d[lr_slot]   = '0;
      if (!lr_hit && !lr_free)
        rr_d = (rr_q == RR_W'(NUM_RSV - 1)) ? '0 : rr_q + RR_W'(1);
    end
  end

  // Reservation table registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q <= '0;
      for (int i = 0; i < int'(NUM_RSV); i++) begin
        rsv_valid_q[i] <= 1'b0;
        rsv_gtid_q[i]  <= '0;
        rsv_gran_q[i]  <= '0;
        rsv_age_q[i]   <= '0;
      end
    end else begin
      rr_q <= rr_d;
      for (int i = 0; i < int'(NUM_RSV); i++) begin
        rsv_valid_q[i] <= rsv_valid_d[i];
        rsv_gtid_q[i]  <= rsv_gtid_d[i];
        rsv_gran_q[i]  <= rsv_gran_d[i];
        rsv_age_q[i]   <= rsv_age_d[i];
      end
    end
  end
endmodule

// File: tb/tb_vx_amo_engine.sv
// Scoreboard bench for vx_amo_engine: directed AMO/LR/SC/drain/timeout/reset scenarios
// against a behavioural cache bank with programmable read latency.

module tb_vx_amo_engine;
  localparam logic [4:0] OP_ADD = 5'b00000, OP_SWAP = 5'b00001, OP_LR = 5'b00010, OP_SC = 5'b00011;
  localparam logic [4:0] OP_XOR = 5'b00100, OP_OR = 5'b01000, OP_AND = 5'b01100, OP_MIN = 5'b10000;
  localparam logic [4:0] OP_MAX = 5'b10100, OP_MINU = 5'b11000, OP_MAXU = 5'b11100;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  vx_amo_core_if  #(.TAG_WIDTH(8), .ADDR_WIDTH(26), .WORD_SIZE(4), .GTID_WIDTH(10)) core_if ();
  vx_amo_cache_if #(.TAG_WIDTH(8), .ADDR_WIDTH(26), .WORD_SIZE(4)) cache_if ();

  vx_amo_engine #(
    .TAG_WIDTH(8), .ADDR_WIDTH(26), .WORD_SIZE(4), .GTID_WIDTH(10), .NUM_RSV(2),
    .RSV_GRAN_BITS(2), .RSV_TIMEOUT(16), .MAX_PENDING(8), .WRITE_ACK(0)
  ) dut (
    .clk(clk), .reset(reset), .core_if(core_if), .cache_if(cache_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- cache bank model ----------------
  typedef struct { logic [7:0] tag; logic [31:0] data; int due; } brsp_t;
  brsp_t       bq[$];
  logic [31:0] mem [0:4095];
  logic        block_writes = 1'b0;
  int          cyc = 0, lat = 2, wr_count = 0, t22_cyc = 0, amo_rd_cyc = 0;
  logic [31:0] last_wr_data = '0;

  assign cache_if.req_ready = !(block_writes && cache_if.req_rw);

  initial begin
    cache_if.rsp_valid = 1'b0;
    cache_if.rsp_tag   = '0;
    cache_if.rsp_data  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bq.size() != 0 && bq[0].due <= cyc) begin
        cache_if.rsp_valid = 1'b1;
        cache_if.rsp_tag   = bq[0].tag;
        cache_if.rsp_data  = bq[0].data;
      end else begin
        cache_if.rsp_valid = 1'b0;
      end
      #1;
      if (!reset) begin
        if (cache_if.req_valid && cache_if.req_ready) begin
          if (cache_if.req_rw) begin
            for (int b = 0; b < 4; b++)
              if (cache_if.req_byteen[b])
                mem[cache_if.req_addr[11:0]][8*b +: 8] = cache_if.req_data[8*b +: 8];
            wr_count++;
            last_wr_data = cache_if.req_data;
          end else begin
            bq.push_back('{cache_if.req_tag, mem[cache_if.req_addr[11:0]], cyc + lat});
            if (cache_if.req_addr == 26'h410) amo_rd_cyc = cyc;
          end
        end
        if (cache_if.rsp_valid && cache_if.rsp_ready) begin
          if (bq[0].tag == 8'd22) t22_cyc = cyc;
          void'(bq.pop_front());
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  typedef struct { logic [7:0] tag; logic [31:0] data; } exp_t;
  exp_t exp_q[$];

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!reset && core_if.rsp_valid && core_if.rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp: got tag %h data %h, none expected", core_if.rsp_tag, core_if.rsp_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_tag", 32'(core_if.rsp_tag), 32'(e.tag));
          check($sformatf("rsp_data_t%0d", e.tag), core_if.rsp_data, e.data);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic expect_rsp(input logic [7:0] tag, input logic [31:0] data);
    exp_q.push_back('{tag, data});
  endtask

  task automatic send(input logic [7:0] tag, input logic [25:0] addr, input logic rw,
                      input logic [31:0] data, input logic amo, input logic [4:0] op,
                      input logic [9:0] gtid);
    int n;
    @(negedge clk);
    core_if.req_valid  = 1'b1;
    core_if.req_tag    = tag;
    core_if.req_addr   = addr;
    core_if.req_rw     = rw;
    core_if.req_byteen = 4'hF;
    core_if.req_data   = data;
    core_if.req_amo    = amo;
    core_if.req_amo_op = op;
    core_if.req_gtid   = gtid;
    #1;
    n = 0;
    while (!core_if.req_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: tag %0d not accepted, required accept within 200 cycles", tag);
    end
    @(negedge clk);
    core_if.req_valid = 1'b0;
    core_if.req_amo   = 1'b0;
    core_if.req_rw    = 1'b0;
  endtask

  task automatic drain_sb();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  typedef struct { logic [4:0] op; logic [31:0] old; logic [31:0] opnd; logic [31:0] newv; } vec_t;
  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int wc, n;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    reset = 1'b1;
    core_if.req_valid = 1'b0; core_if.req_tag = '0; core_if.req_addr = '0; core_if.req_rw = 1'b0;
    core_if.req_byteen = '0; core_if.req_data = '0; core_if.req_amo = 1'b0;
    core_if.req_amo_op = '0; core_if.req_gtid = '0; core_if.rsp_ready = 1'b0;
    #2;
    check("rst_core_req_ready", 32'(core_if.req_ready), 32'd1);
    check("rst_cache_req_valid", 32'(cache_if.req_valid), 32'd0);
    check("rst_core_rsp_valid", 32'(core_if.rsp_valid), 32'd0);
    check("rst_cache_rsp_ready", 32'(cache_if.rsp_ready), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    core_if.rsp_ready = 1'b1;

    // LR then successful SC; a second SC finds the table empty
    mem[12'h100] = 32'd7;
    expect_rsp(8'd1, 32'd7);  send(8'd1, 26'h100, 1'b0, 32'd0, 1'b1, OP_LR, 10'd5);
    expect_rsp(8'd2, 32'd0);  send(8'd2, 26'h100, 1'b0, 32'd9, 1'b1, OP_SC, 10'd5);
    drain_sb();
    check("sc_ok_mem", mem[12'h100], 32'd9);
    expect_rsp(8'd3, 32'd1);  send(8'd3, 26'h100, 1'b0, 32'd11, 1'b1, OP_SC, 10'd5);
    drain_sb();
    check("sc_after_clear_mem", mem[12'h100], 32'd9);

    // Foreign write to the same granule kills the reservation
    expect_rsp(8'd4, 32'd9);  send(8'd4, 26'h100, 1'b0, 32'd0, 1'b1, OP_LR, 10'd5);
    send(8'd50, 26'h101, 1'b1, 32'h55, 1'b0, OP_ADD, 10'd3);
    expect_rsp(8'd5, 32'd1);  send(8'd5, 26'h100, 1'b0, 32'd12, 1'b1, OP_SC, 10'd5);
    drain_sb();
    check("sc_inval_mem", mem[12'h100], 32'd9);
    check("passthru_wr_mem", mem[12'h101], 32'h55);

    // Two-entry table: third LR evicts the first via round robin
    mem[12'h200] = 32'h10; mem[12'h204] = 32'h20; mem[12'h208] = 32'h30;
    expect_rsp(8'd6, 32'h10); send(8'd6, 26'h200, 1'b0, 32'd0, 1'b1, OP_LR, 10'd1);
    expect_rsp(8'd7, 32'h20); send(8'd7, 26'h204, 1'b0, 32'd0, 1'b1, OP_LR, 10'd2);
    expect_rsp(8'd8, 32'h30); send(8'd8, 26'h208, 1'b0, 32'd0, 1'b1, OP_LR, 10'd3);
    expect_rsp(8'd9, 32'd1);  send(8'd9, 26'h200, 1'b0, 32'h11, 1'b1, OP_SC, 10'd1);
    expect_rsp(8'd10, 32'd0); send(8'd10, 26'h208, 1'b0, 32'h33, 1'b1, OP_SC, 10'd3);
    drain_sb();
    check("evict_sc1_mem", mem[12'h200], 32'h10);
    check("evict_sc3_mem", mem[12'h208], 32'h33);

    // Arithmetic ops, including signed vs unsigned MAX and an unknown code acting as SWAP
    vecs.push_back('{OP_ADD,  32'hFFFF_FFFE, 32'h0000_0005, 32'h0000_0003});
    vecs.push_back('{OP_SWAP, 32'h1234_5678, 32'hAABB_CCDD, 32'hAABB_CCDD});
    vecs.push_back('{OP_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0});
    vecs.push_back('{OP_OR,   32'hF0F0_0000, 32'h0000_F0F0, 32'hF0F0_F0F0});
    vecs.push_back('{OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000});
    vecs.push_back('{OP_MIN,  32'h0000_0005, 32'hFFFF_FFFE, 32'hFFFF_FFFE});
    vecs.push_back('{OP_MAX,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001});
    vecs.push_back('{OP_MINU, 32'h0000_0005, 32'hFFFF_FFFE, 32'h0000_0005});
    vecs.push_back('{OP_MAXU, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF});
    vecs.push_back('{5'b00101, 32'h1111_1111, 32'h2222_2222, 32'h2222_2222});
    foreach (vecs[i]) begin
      logic [11:0] a;
      a = 12'h300 + 12'(4 * i);
      mem[a] = vecs[i].old;
      wc = wr_count;
      expect_rsp(8'(30 + i), vecs[i].old);
      send(8'(30 + i), 26'(a), 1'b0, vecs[i].opnd, 1'b1, vecs[i].op, 10'd9);
      drain_sb();
      check($sformatf("amo%0d_mem", i), mem[a], vecs[i].newv);
      check($sformatf("amo%0d_wrdata", i), last_wr_data, vecs[i].newv);
      check($sformatf("amo%0d_wrcount", i), 32'(wr_count - wc), 32'd1);
    end

    // Three slow pass-through reads drain before the AMO read is issued
    lat = 10;
    mem[12'h400] = 32'hA0; mem[12'h401] = 32'hA1; mem[12'h402] = 32'hA2; mem[12'h410] = 32'd100;
    expect_rsp(8'd20, 32'hA0); send(8'd20, 26'h400, 1'b0, 32'd0, 1'b0, OP_ADD, 10'd4);
    expect_rsp(8'd21, 32'hA1); send(8'd21, 26'h401, 1'b0, 32'd0, 1'b0, OP_ADD, 10'd4);
    expect_rsp(8'd22, 32'hA2); send(8'd22, 26'h402, 1'b0, 32'd0, 1'b0, OP_ADD, 10'd4);
    expect_rsp(8'd23, 32'd100); send(8'd23, 26'h410, 1'b0, 32'd5, 1'b1, OP_ADD, 10'd4);
    drain_sb();
    lat = 2;
    check("drain_add_mem", mem[12'h410], 32'd105);
    check("drain_rd_delay", 32'(amo_rd_cyc - t22_cyc), 32'd2);

    // Reservation expires after 16 cycles of age
    mem[12'h500] = 32'h77;
    expect_rsp(8'd24, 32'h77); send(8'd24, 26'h500, 1'b0, 32'd0, 1'b1, OP_LR, 10'd7);
    drain_sb();
    repeat (20) @(negedge clk);
    expect_rsp(8'd25, 32'd1); send(8'd25, 26'h500, 1'b0, 32'h1, 1'b1, OP_SC, 10'd7);
    drain_sb();
    check("timeout_mem", mem[12'h500], 32'h77);

    // Reset while the write is back-pressured: no write, no response
    mem[12'h600] = 32'd3;
    block_writes = 1'b1;
    wc = wr_count;
    send(8'd26, 26'h600, 1'b0, 32'd4, 1'b1, OP_ADD, 10'd1);
    #1;
    n = 0;
    while (!(cache_if.req_valid && cache_if.req_rw) && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("wr_req_seen", 32'(cache_if.req_valid && cache_if.req_rw), 32'd1);
    check("wr_req_data", cache_if.req_data, 32'd7);
    @(negedge clk);
    #1;
    check("wr_hold_valid", 32'(cache_if.req_valid), 32'd1);
    check("wr_hold_data", cache_if.req_data, 32'd7);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_cache_valid", 32'(cache_if.req_valid), 32'd0);
    check("mid_rst_core_rsp_valid", 32'(core_if.rsp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    block_writes = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_rst_no_write", 32'(wr_count - wc), 32'd0);
    check("mid_rst_mem", mem[12'h600], 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vx_amo_engine.md
# vx_amo_engine

Parametrised atomic-memory-operation engine that sits between the core/crossbar request port and one cache bank. It executes RISC-V 'A' operations as read, compute and conditional write sequences, and forwards all non-AMO traffic unchanged. It extends the single-reservation, single-word AMO unit in three ways: a multi-entry per-thread LR reservation table with granule-based invalidation and timeout, draining of in-flight pass-through reads before an AMO starts, and an optional write-acknowledge wait.

## Interface

Parameters:
- TAG_WIDTH, 8: request/response tag width.
- ADDR_WIDTH, 26: word address width.
- WORD_SIZE, 4: bytes per word; data width W = 8*WORD_SIZE (4 or 8).
- GTID_WIDTH, 10: global thread id width.
- NUM_RSV, 4: reservation table entries (≥1).
- RSV_GRAN_BITS, 2: low word-address bits ignored for reservation match.
- RSV_TIMEOUT, 1024: cycles before a reservation expires; 0 means no expiry.
- MAX_PENDING, 8: maximum outstanding pass-through reads.
- WRITE_ACK, 0: 1 means the bank returns one response per write, and the engine waits for it.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- core_req_valid / core_req_ready  in / out  1  request handshake.
- core_req_tag  in  TAG_WIDTH.
- core_req_addr  in  ADDR_WIDTH.
- core_req_rw  in  1  (1 = write).
- core_req_byteen  in  WORD_SIZE.
- core_req_data  in  W.
- core_req_amo  in  1  request is an AMO.
- core_req_amo_op  in  5  RISC-V funct5.
- core_req_gtid  in  GTID_WIDTH.
- core_rsp_valid / core_rsp_ready  out / in  1.
- core_rsp_tag  out  TAG_WIDTH.
- core_rsp_data  out  W.
- cache_req_valid / cache_req_ready  out / in  1.
- cache_req_tag, cache_req_addr, cache_req_rw, cache_req_byteen, cache_req_data  out  widths as core side.
- cache_rsp_valid / cache_rsp_ready  in / out  1.
- cache_rsp_tag  in  TAG_WIDTH.
- cache_rsp_data  in  W.

## Operation

- **Op codes:** ADD=00000, SWAP=00001, LR=00010, SC=00011, XOR=00100, OR=01000, AND=01100, MIN=10000, MAX=10100, MINU=11000, MAXU=11100. Any other code is handled as SWAP.
- **States:** IDLE, DRAIN, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RSP.
- **IDLE pass-through:**
  - cache_req_* = core_req_*.
  - core_req_ready = cache_req_ready, and additionally requires pending < MAX_PENDING for reads.
  - core_rsp_* = cache_rsp_*.
  - cache_rsp_ready = core_rsp_ready.
- **IDLE with an AMO:** core_req_ready = 1 and cache_req_valid = 0. On handshake, the request is latched. Next state is DRAIN if pending ≠ 0, else RD_REQ.
- **Pending counter:** +1 on each pass-through read handshake, −1 on each cache response handshake in IDLE or DRAIN. Simultaneous +1/−1 nets to 0.
- **DRAIN:** core_req_ready = 0. Cache responses are still forwarded to the core. Move to RD_REQ when pending = 0.
- **RD_REQ:** read of the latched address with rw = 0. Advance on handshake.
- **RD_WAIT:** cache_rsp_ready = 1. On response, latch old data and evaluate sc_ok from the current table.
  - LR goes to RSP.
  - SC with sc_ok goes to WR_REQ.
  - SC without sc_ok goes to RSP and does not write.
  - All other ops go to WR_REQ.
- **WR_REQ:** rw = 1, data = f(old, operand), using the latched byteen.
  - MIN/MAX compare signed at W bits; MINU/MAXU compare unsigned. ADD wraps modulo 2^W.
  - On handshake, go to WR_WAIT if WRITE_ACK = 1, else RSP.
- **WR_WAIT:** cache_rsp_ready = 1. The write response is consumed and not forwarded. Then go to RSP.
- **RSP:** core_rsp_valid = 1 with the latched tag.
  - Data is old for all ops except SC.
  - SC returns 0 on success and 1 on failure.
  - On handshake, return to IDLE.
- **Reservation table:** each entry holds {valid, gtid, granule = addr >> RSV_GRAN_BITS, age}.
  - **LR (at RD_WAIT response):** reuse the entry with the same gtid; else use the lowest free entry; else replace the entry at the round-robin pointer, then increment the pointer. The written entry gets age = 0.
  - **sc_ok:** true when some valid entry has matching gtid and granule. At the SC read response, that gtid's entry is cleared whether or not the SC succeeds.
  - **Invalidation:** every write handshake on the cache port (pass-through, AMO or SC) clears all valid entries whose granule matches, for any gtid.
  - **Ageing:** if RSV_TIMEOUT ≠ 0, age increments every cycle while the entry is valid. The entry is cleared when age reaches RSV_TIMEOUT−1.
  - **Same-cycle conflicts:** LR write beats expiry of the same entry. An entry that expires in the same cycle as an SC evaluation counts as invalid.

## Timing

- **Reset:**
  - State = IDLE; pending = 0; all table entries invalid; RR pointer = 0.
  - Outputs with inputs low: all valids 0, core_req_ready = cache_req_ready.
- **AMO latency** (no pending reads, ready bank, bank read latency L): accept in cycle 0, read request in cycle 1, write request in cycle 2+L, core response in cycle 3+L. Add 1 cycle plus ack latency when WRITE_ACK = 1.
- LR and failed SC skip the write, so the core response comes in cycle 2+L.
- Only one AMO is in flight. No pass-through request is accepted from AMO accept until RSP completes.
- **Mid-operation reset:** asynchronous return to IDLE. The latched request is lost and no response is issued.
- **Back-pressure:** all outputs stay stable while valid is high and ready is low.

## Test plan

- LR by gtid 5 at 0x100 (memory holds 7), then SC by gtid 5 writing 9 → LR returns 7, SC returns 0, memory holds 9, table empty.
- LR by gtid 5 at 0x100, pass-through write by gtid 3 to 0x101 (same granule with GRAN = 2), then SC by gtid 5 → SC returns 1, no write issued, memory unchanged.
- NUM_RSV = 2: LR by gtids 1, 2 and 3 in turn, then SC by gtid 1 → gtid 1's entry was evicted, SC fails with 1, and SC by gtid 3 succeeds.
- AMOMAX with old 0xFFFFFFFF and operand 1 (W = 32) → writes 1 and returns 0xFFFFFFFF. AMOMAXU on the same values writes 0xFFFFFFFF.
- Issue 3 pass-through reads with bank latency 10, then AMOADD → engine stays in DRAIN until 3 responses have been forwarded, the read request issues the cycle after pending reaches 0, and the AMO response comes last.
- RSV_TIMEOUT = 16: LR, idle 20 cycles, then SC → returns 1. Also assert reset during WR_REQ → next cycle state is IDLE, core_rsp_valid = 0, no write is issued.
